// File: rtl/clk_div_pkg.sv
// ============================================================================
// clk_div_pkg : shared mode encoding and default constants for multi_clk_div
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_div_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    localparam int CLK_DIV_DEF_CNT_W = 27;
    localparam int CLK_DIV_DEF_DIV   = 50000000;

endpackage

`default_nettype wire

// File: rtl/clk_div_ch.sv
// ============================================================================
// clk_div_ch : one divider channel (counter, pending/active config, outputs)
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CLK_DIV_DEF_CNT_W,
    parameter int DEF_DIV = CLK_DIV_DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_mode,
    output logic             o_div,
    output logic             o_tick
);

    localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_div;
    logic [CNT_W-1:0] r_pend_div;
    mode_e            r_act_mode;
    mode_e            r_pend_mode;
    logic             r_pend_vld;
    logic             r_div;
    logic             r_tick;

    logic             w_idle;
    logic             w_tc;
    logic [CNT_W-1:0] w_nxt_div;
    mode_e            w_nxt_mode;
    logic             w_mode_chg;

    // An idle channel (disabled or N=0) takes a write straight into its
    // active registers; a running one only swaps at terminal count.
    always_comb begin
        w_idle     = !i_en || (r_act_div == '0);
        w_tc       = !w_idle && (r_cnt == (r_act_div - c_ONE));
        w_nxt_div  = r_act_div;
        w_nxt_mode = r_act_mode;
        if (w_idle && i_we) begin
            w_nxt_div  = i_div;
            w_nxt_mode = mode_e'(i_mode);
        end else if ((w_idle || w_tc) && r_pend_vld) begin
            w_nxt_div  = r_pend_div;
            w_nxt_mode = r_pend_mode;
        end
        w_mode_chg = (w_nxt_mode != r_act_mode);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_act_div   <= c_DEF_DIV;
            r_pend_div  <= c_DEF_DIV;
            r_act_mode  <= MODE_TOGGLE;
            r_pend_mode <= MODE_TOGGLE;
            r_pend_vld  <= 1'b0;
            r_div       <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_act_div  <= w_nxt_div;
            r_act_mode <= w_nxt_mode;

            if (i_we) begin
                r_pend_div  <= i_div;
                r_pend_mode <= mode_e'(i_mode);
                r_pend_vld  <= !w_idle;
            end else if (w_idle || w_tc) begin
                r_pend_vld  <= 1'b0;
            end

            if (!i_en) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_div  <= 1'b0;
            end else if (w_idle) begin
                // Stalled at N=0: a toggle output holds, a pulse output idles low
                r_cnt  <= '0;
                r_tick <= 1'b0;
                if (w_mode_chg || (w_nxt_mode == MODE_PULSE)) begin
                    r_div <= 1'b0;
                end
            end else begin
                r_cnt  <= w_tc ? '0 : (r_cnt + c_ONE);
                r_tick <= w_tc;
                if (w_mode_chg) begin
                    r_div <= 1'b0;
                end else if (w_tc) begin
                    r_div <= (r_act_mode == MODE_TOGGLE) ? ~r_div : 1'b1;
                end else if (r_act_mode == MODE_PULSE) begin
                    r_div <= 1'b0;
                end
            end
        end
    end

    assign o_div  = r_div;
    assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/multi_clk_div.sv
// ============================================================================
// multi_clk_div : N-channel programmable clock divider / blinker
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = CLK_DIV_DEF_CNT_W,
    parameter int DEF_DIV = CLK_DIV_DEF_DIV,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] div_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic              cfg_err
);

    logic [NUM_CH-1:0] w_we;
    logic              w_ch_ok;
    logic              r_cfg_err;

    always_comb begin
        w_ch_ok = (32'(cfg_ch) < 32'(NUM_CH));
        for (int i = 0; i < NUM_CH; i++) begin
            w_we[i] = cfg_we && (32'(cfg_ch) == 32'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_ch_ok;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_en   (ch_en[gi]),
            .i_we   (w_we[gi]),
            .i_div  (cfg_div),
            .i_mode (cfg_mode),
            .o_div  (div_o[gi]),
            .o_tick (tick_o[gi])
        );
    end

endmodule

`default_nettype wire
